// File: rtl/imem_fetch_port.sv
// Instruction memory with a one-cycle handshaked fetch port and a run-time programming port.
// The response register holds one word; flush and reset drop it and leave memory untouched.
module imem_fetch_port #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 256,
  parameter bit                    BYTE_ADDR  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_fault,
  input  logic                  prog_en,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [ADDR_WIDTH-1:0] prog_cnt
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] prog_cnt_q;
  logic [ADDR_WIDTH-1:0] req_idx, prog_idx;
  logic                  req_in_range, prog_in_range;
  logic                  accept, wr_en;

  assign req_idx  = BYTE_ADDR ? (req_addr >> 2) : req_addr;
  assign prog_idx = BYTE_ADDR ? (prog_addr >> 2) : prog_addr;

  // Every bit above the index field must be zero; no aliasing onto low words.
  assign req_in_range  = (req_idx >> IdxW) == '0;
  assign prog_in_range = (prog_idx >> IdxW) == '0;

  assign rsp_valid = (state_q == StFull);
  assign req_ready = !prog_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign wr_en     = prog_en && prog_we && prog_in_range;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else if (rsp_valid && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Read register doubles as the held response while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
      fault_q   <= 1'b0;
    end else if (accept) begin
      rd_data_q <= mem[req_idx[IdxW-1:0]];
      fault_q   <= !req_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[prog_idx[IdxW-1:0]] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prog_cnt_q <= '0;
    end else if (wr_en) begin
      prog_cnt_q <= prog_cnt_q + 1'b1;
    end
  end

  assign rsp_data  = fault_q ? FILL_WORD : rd_data_q;
  assign rsp_fault = fault_q;
  assign prog_cnt  = prog_cnt_q;

endmodule
